// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter producing the registered select for a downstream 8:1 word mux.
// Optional grant-length limit compiled in with `define ARB_TIMEOUT_EN (uses MAX_HOLD).
module arb8_rr #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       timeout_d;
  logic       hold_clr, hold_inc;

  logic [2:0] win_idx, scan_idx;
  logic       win_found;
  logic       rel_std, expire;

  // First requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q;

  // Expiry only counts as a timeout when nothing else would release this cycle.
  assign expire = (state_q == BUSY) && (hold_q == HOLD_LIM) && !rel_std;

  always_comb begin
    hold_d = hold_q;
    if (hold_clr)      hold_d = 8'd0;
    else if (hold_inc) hold_d = hold_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign expire     = 1'b0;
  assign timeout    = 1'b0;
  assign unused_cfg = ^{HOLD_LIM, timeout_d, hold_clr, hold_inc};
`endif

  assign rel_std = done || !req[sel_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    hold_clr  = 1'b0;
    hold_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = 8'h00;
        valid_d = 1'b0;
        if (win_found) begin
          grant_d  = 8'b1 << win_idx;
          sel_d    = win_idx;
          valid_d  = 1'b1;
          state_d  = BUSY;
          hold_clr = 1'b1;
        end
      end
      BUSY: begin
        if (rel_std || expire) begin
          grant_d   = 8'h00;
          valid_d   = 1'b0;
          ptr_d     = sel_q + 3'd1;
          state_d   = IDLE;
          timeout_d = expire;
          hold_clr  = 1'b1;
        end else begin
          hold_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule
